// File: rtl/mmio_button_ctrl_pkg.sv
// mmio_button_ctrl_pkg
// Shared constants for the memory-mapped push-button peripheral:
//   BUS_W              processor data bus width
//   DEFAULT_BASE_ADDR  default word address of register offset 0
//   OFF_*              register offsets inside the 4-word window
package mmio_button_ctrl_pkg;

  localparam int BUS_W             = 32;
  localparam int DEFAULT_BASE_ADDR = 1000;

  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_EVENT  = 2'd1;
  localparam logic [1:0] OFF_MASK   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

endpackage

// File: rtl/mmio_button_ctrl_btn_debounce.sv
// mmio_button_ctrl_btn_debounce
// One button channel: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle rise indication.
// Ports:
//   clock   system clock
//   reset   synchronous, active-high; clears every flop
//   btn     raw asynchronous button level (1 = pressed)
//   stable  debounced level
//   rise    high in the cycle whose closing edge takes stable 0->1
module mmio_button_ctrl_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The counter restarts on any agreement, so only an uninterrupted run of
  // DEBOUNCE_CYCLES disagreeing samples moves the debounced level.
  assign accept = (sync_p1 != stable) && (cnt == CNT_MAX);
  assign rise   = accept && sync_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      // synchroniser stage boundary
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // debounce stage boundary
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_button_ctrl.sv
// mmio_button_ctrl
// Multi-channel push-button peripheral on the data-memory bus.
// Register window (word addresses BASE_ADDR..BASE_ADDR+3):
//   +0 STATUS  RO   debounced levels
//   +1 EVENT   W1C  sticky press events
//   +2 MASK    RW   interrupt enables
//   +3 reserved, reads 0
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   btn_in[NUM_BTN]       raw button levels
//   address_dmem, data,   processor data-memory bus (word address,
//   wren                  write data, write enable)
//   q_io                  registered read data, valid one cycle after address
//   io_sel                registered window hit; wrapper muxes q_io over RAM
//   irq                   registered OR of EVENT & MASK
// Build option: define MMIO_BTN_READ_CLEAR_EN so that reading EVENT also
// clears the bits returned by that read.
module mmio_button_ctrl
  import mmio_button_ctrl_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BASE_ADDR       = DEFAULT_BASE_ADDR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [BUS_W-1:0]   address_dmem,
  input  logic [BUS_W-1:0]   data,
  input  logic               wren,
  output logic [BUS_W-1:0]   q_io,
  output logic               io_sel,
  output logic               irq
);

  logic [NUM_BTN-1:0] stable_vec;
  logic [NUM_BTN-1:0] rise_vec;
  logic [NUM_BTN-1:0] event_q;
  logic [NUM_BTN-1:0] mask_q;
  logic [NUM_BTN-1:0] event_next;
  logic [NUM_BTN-1:0] mask_next;
  logic [NUM_BTN-1:0] w1c_clr;
  logic [NUM_BTN-1:0] rd_clr;
  logic [NUM_BTN-1:0] wr_bits;
  logic [BUS_W-1:0]   offset_full;
  logic [1:0]         offset;
  logic               hit;
  logic [BUS_W-1:0]   rd_data;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    mmio_button_ctrl_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock (clock),
      .reset (reset),
      .btn   (btn_in[i]),
      .stable(stable_vec[i]),
      .rise  (rise_vec[i])
    );
  end

  // Unsigned subtraction wraps addresses below the base to huge values, so a
  // single "upper bits zero" test covers both window bounds.
  assign offset_full = address_dmem - BUS_W'(BASE_ADDR);
  assign hit         = (offset_full[BUS_W-1:2] == '0);
  assign offset      = offset_full[1:0];
  assign wr_bits     = NUM_BTN'(data);

  assign w1c_clr = (wren && hit && offset == OFF_EVENT) ? wr_bits : '0;

`ifdef MMIO_BTN_READ_CLEAR_EN
  assign rd_clr = (hit && !wren && offset == OFF_EVENT) ? event_q : '0;
`else
  assign rd_clr = '0;
`endif

  // New events are OR-ed in last so a same-edge clear never loses a press.
  assign event_next = (event_q & ~w1c_clr & ~rd_clr) | rise_vec;
  assign mask_next  = (wren && hit && offset == OFF_MASK) ? wr_bits : mask_q;

  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_STATUS: rd_data = BUS_W'(stable_vec);
      OFF_EVENT:  rd_data = BUS_W'(event_q);
      OFF_MASK:   rd_data = BUS_W'(mask_q);
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      event_q <= '0;
      mask_q  <= '0;
      q_io    <= '0;
      io_sel  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      // register / read-port stage boundary
      event_q <= event_next;
      mask_q  <= mask_next;
      q_io    <= hit ? rd_data : '0;
      io_sel  <= hit;
      irq     <= |(event_next & mask_next);
    end
  end

endmodule

// File: tb/tb_mmio_button_ctrl.sv
module tb_mmio_button_ctrl;

  localparam int NB   = 4;
  localparam int DEB  = 4;
  localparam int BASE = 1000;

  logic          clock;
  logic          reset;
  logic [NB-1:0] btn_in;
  logic [31:0]   address_dmem;
  logic [31:0]   data;
  logic          wren;
  logic [31:0]   q_io;
  logic          io_sel;
  logic          irq;

  int n_checks;
  int n_pass;

  mmio_button_ctrl #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DEB),
    .BASE_ADDR(BASE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_in      (btn_in),
    .address_dmem(address_dmem),
    .data        (data),
    .wren        (wren),
    .q_io        (q_io),
    .io_sel      (io_sel),
    .irq         (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bus read: address presented for one edge, result sampled 1 time unit later.
  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
    address_dmem = a;
    wren         = 1'b0;
    @(posedge clock);
    #1;
    d            = q_io;
    s            = io_sel;
    address_dmem = 32'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    address_dmem = a;
    data         = v;
    wren         = 1'b1;
    @(posedge clock);
    #1;
    wren         = 1'b0;
    address_dmem = 32'd0;
    data         = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        s;
    btn_in = 4'b1111;
    reset  = 1'b1;
    idle(2);
    n_checks++;
    if (q_io !== 32'd0) $display("FAIL reset_q_io got %h want 0", q_io); else n_pass++;
    n_checks++;
    if (io_sel !== 1'b0) $display("FAIL reset_io_sel got %b want 0", io_sel); else n_pass++;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else n_pass++;
    reset = 1'b0;
    rd(BASE, d, s);
    n_checks++;
    if (d !== 32'd0 || s !== 1'b1)
      $display("FAIL reset_status_read got %h/%b want 0/1", d, s);
    else n_pass++;
    btn_in = '0;
    reset  = 1'b1;
    idle(2);
    reset  = 1'b0;
    idle(2);
  endtask

  task automatic test_debounce;
    logic [31:0] d;
    logic        s;
    btn_in[0] = 1'b1;
    @(posedge clock);          // edge 0: synchroniser samples the press
    repeat (4) @(posedge clock);
    #1;
    rd(BASE, d, s);            // captured at edge 5, sees stable before update
    n_checks++;
    if (d !== 32'd0) $display("FAIL deb_early got %h want 0", d); else n_pass++;
    rd(BASE, d, s);            // captured at edge 6
    n_checks++;
    if (d !== 32'h1 || s !== 1'b1)
      $display("FAIL deb_status got %h/%b want 1/1", d, s);
    else n_pass++;
    rd(BASE + 1, d, s);
    n_checks++;
    if (d !== 32'h1) $display("FAIL deb_event got %h want 1", d); else n_pass++;
    wr(BASE + 1, 32'h1);
    btn_in[0] = 1'b0;
    idle(10);
    rd(BASE, d, s);
    n_checks++;
    if (d !== 32'd0) $display("FAIL deb_release_status got %h want 0", d); else n_pass++;
    rd(BASE + 1, d, s);
    n_checks++;
    if (d !== 32'd0) $display("FAIL deb_release_event got %h want 0", d); else n_pass++;
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    logic        s;
    btn_in[1] = 1'b1;
    idle(3);
    btn_in[1] = 1'b0;
    idle(20);
    rd(BASE, d, s);
    n_checks++;
    if (d !== 32'd0) $display("FAIL glitch_status got %h want 0", d); else n_pass++;
    rd(BASE + 1, d, s);
    n_checks++;
    if (d !== 32'd0) $display("FAIL glitch_event got %h want 0", d); else n_pass++;
  endtask

  task automatic test_mask_irq;
    logic [31:0] d;
    logic        s;
    wr(BASE + 2, 32'hFFFF_FFFF);
    rd(BASE + 2, d, s);
    n_checks++;
    if (d !== 32'hF) $display("FAIL mask_width got %h want f", d); else n_pass++;
    wr(BASE + 2, 32'h2);
    rd(BASE + 2, d, s);
    n_checks++;
    if (d !== 32'h2) $display("FAIL mask_rw got %h want 2", d); else n_pass++;
    btn_in[1] = 1'b1;
    @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_early got %b want 0", irq); else n_pass++;
    idle(1);                   // edge 5: EVENT[1] sets, irq follows same edge
    n_checks++;
    if (irq !== 1'b1) $display("FAIL irq_set got %b want 1", irq); else n_pass++;
    wr(BASE + 1, 32'h2);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_clear got %b want 0", irq); else n_pass++;
    rd(BASE + 1, d, s);
    n_checks++;
    if (d !== 32'd0) $display("FAIL irq_event_cleared got %h want 0", d); else n_pass++;
    btn_in[1] = 1'b0;
    idle(10);
  endtask

  task automatic test_collision;
    logic [31:0] d;
    logic        s;
    btn_in[2] = 1'b1;
    @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    wr(BASE + 1, 32'h4);       // W1C lands on edge 5, same as the event
    wr(BASE + 1, 32'h0);       // writing 0 must leave the bit alone
    rd(BASE + 1, d, s);
    n_checks++;
    if (d !== 32'h4) $display("FAIL collision_event got %h want 4", d); else n_pass++;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL collision_irq_masked got %b want 0", irq); else n_pass++;
    wr(BASE + 1, 32'h4);
    rd(BASE + 1, d, s);
    n_checks++;
    if (d !== 32'd0) $display("FAIL collision_w1c got %h want 0", d); else n_pass++;
    btn_in[2] = 1'b0;
    idle(10);
  endtask

  task automatic test_decode;
    logic [31:0] d;
    logic        s;
    rd(BASE + 3, d, s);
    n_checks++;
    if (d !== 32'd0 || s !== 1'b1)
      $display("FAIL rsvd_read got %h/%b want 0/1", d, s);
    else n_pass++;
    rd(BASE + 4, d, s);
    n_checks++;
    if (d !== 32'd0 || s !== 1'b0)
      $display("FAIL above_window got %h/%b want 0/0", d, s);
    else n_pass++;
    rd(BASE - 1, d, s);
    n_checks++;
    if (s !== 1'b0) $display("FAIL below_window io_sel got %b want 0", s); else n_pass++;
    wr(BASE + 6, 32'hF);       // aliases MASK's low offset bits, outside window
    rd(BASE + 2, d, s);
    n_checks++;
    if (d !== 32'h2) $display("FAIL outside_write got %h want 2", d); else n_pass++;
  endtask

  task automatic test_read_clear;
    logic [31:0] d;
    logic        s;
    btn_in[3] = 1'b1;
    idle(12);
    rd(BASE + 1, d, s);
    n_checks++;
    if (d !== 32'h8) $display("FAIL rc_first got %h want 8", d); else n_pass++;
    rd(BASE + 1, d, s);
    n_checks++;
`ifdef MMIO_BTN_READ_CLEAR_EN
    if (d !== 32'h0) $display("FAIL rc_second got %h want 0", d); else n_pass++;
`else
    if (d !== 32'h8) $display("FAIL rc_second got %h want 8", d); else n_pass++;
`endif
    wr(BASE + 1, 32'h8);
    btn_in[3] = 1'b0;
    idle(10);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic        s;
    btn_in[0] = 1'b1;
    idle(2);
    reset = 1'b1;
    idle(1);                   // reset edge r
    reset = 1'b0;
    n_checks++;
    if (q_io !== 32'd0 || io_sel !== 1'b0 || irq !== 1'b0)
      $display("FAIL midreset_outputs got %h/%b/%b want 0/0/0", q_io, io_sel, irq);
    else n_pass++;
    repeat (5) @(posedge clock);
    #1;
    rd(BASE, d, s);            // edge r+6: stable updates here, read sees old
    n_checks++;
    if (d !== 32'd0) $display("FAIL midreset_early got %h want 0", d); else n_pass++;
    rd(BASE, d, s);
    n_checks++;
    if (d !== 32'h1) $display("FAIL midreset_status got %h want 1", d); else n_pass++;
    rd(BASE + 1, d, s);
    n_checks++;
    if (d !== 32'h1) $display("FAIL midreset_event got %h want 1", d); else n_pass++;
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b1;
    btn_in       = '0;
    address_dmem = 32'd0;
    data         = 32'd0;
    wren         = 1'b0;
    idle(1);
    test_reset;
    test_debounce;
    test_glitch;
    test_mask_irq;
    test_collision;
    test_decode;
    test_read_clear;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
